// File: rtl/arb_pkg.sv
// Shared encodings for the arbiter-cell upstream handshake and root FSM.
// Values match the arbiter cell so trees and the root interoperate directly.
package arb_pkg;

  localparam logic [1:0] HS_IDLE    = 2'd0;
  localparam logic [1:0] HS_REQUEST = 2'd1;
  localparam logic [1:0] HS_LOCK    = 2'd2;
  localparam logic [1:0] HS_RELEASE = 2'd3;

  localparam logic BOOL_TRUE  = 1'b1;
  localparam logic BOOL_FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_GRANT = 2'd1,
    ST_OWNED = 2'd2
  } root_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last, wrapping.
// o_vld is low when no request is set.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_vld,
  output logic [IW-1:0] o_idx
);

  int w_p;

  // Scan farthest-to-nearest so the nearest requester after i_last wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_p   = 0;
    for (int off = N; off >= 1; off--) begin
      w_p = (int'(i_last) + off) % N;
      if (i_req[w_p]) begin
        o_vld = 1'b1;
        o_idx = IW'(w_p);
      end
    end
  end

endmodule

// File: rtl/token_root_ctrl.sv
// Root token responder for arbiter trees: holds the token, grants round-robin, reclaims on release.
// Optional WATCHDOG_EN adds a sticky per-ownership hold timeout flag.
module token_root_ctrl
  import arb_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int HOLD_TIMEOUT = 1024,
  parameter int CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*NUM_PORTS-1:0]       sub_req,
  output logic [NUM_PORTS-1:0]         sub_ack,
  output logic [$clog2(NUM_PORTS)-1:0] owner,
  output logic                         owned,
  output logic [CNT_W-1:0]             grant_cnt,
  output logic                         proto_err,
  output logic                         timeout_err
);

  localparam int IW = $clog2(NUM_PORTS);

  root_state_e          r_state, w_state_nxt;
  logic [NUM_PORTS-1:0] r_ack, w_ack_nxt;
  logic [IW-1:0]        r_owner, w_owner_nxt;
  logic [IW-1:0]        r_rr_last, w_rr_nxt;
  logic                 r_owned, w_owned_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_perr, w_perr_nxt;

  logic [NUM_PORTS-1:0] w_req, w_rel, w_own_mask;
  logic                 w_pick_vld;
  logic [IW-1:0]        w_pick_idx;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_dec
    assign w_req[k] = (sub_req[2*k +: 2] == HS_REQUEST);
    assign w_rel[k] = (sub_req[2*k +: 2] == HS_RELEASE);
  end

  assign w_own_mask = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_owner;

  rr_pick #(.N(NUM_PORTS), .IW(IW)) u_pick (
    .i_req  (w_req),
    .i_last (r_rr_last),
    .o_vld  (w_pick_vld),
    .o_idx  (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_HOLD;
      r_ack     <= '0;
      r_owner   <= '0;
      r_rr_last <= IW'(NUM_PORTS-1);
      r_owned   <= 1'b0;
      r_cnt     <= '0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= w_ack_nxt;
      r_owner   <= w_owner_nxt;
      r_rr_last <= w_rr_nxt;
      r_owned   <= w_owned_nxt;
      r_cnt     <= w_cnt_nxt;
      r_perr    <= w_perr_nxt;
    end
  end

  // Ack is registered: it is loaded on HOLD->GRANT so it is high exactly while in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = '0;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_last;
    w_owned_nxt = r_owned;
    w_cnt_nxt   = r_cnt;
    w_perr_nxt  = r_perr;
    case (r_state)
      ST_HOLD: begin
        if (w_pick_vld) begin
          w_state_nxt            = ST_GRANT;
          w_owner_nxt            = w_pick_idx;
          w_rr_nxt               = w_pick_idx;
          w_ack_nxt[w_pick_idx]  = BOOL_TRUE;
        end
      end
      ST_GRANT: begin
        w_state_nxt = ST_OWNED;
        w_owned_nxt = 1'b1;
        if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
        if (|w_rel) w_perr_nxt = 1'b1;
      end
      ST_OWNED: begin
        if (w_rel[r_owner]) begin
          w_state_nxt = ST_HOLD;
          w_owned_nxt = 1'b0;
        end
        if (|(w_rel & ~w_own_mask)) w_perr_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_owned_nxt = 1'b0;
      end
    endcase
  end

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(HOLD_TIMEOUT + 1);

  logic [WDW-1:0] r_wd_cnt;
  logic           r_terr;

  // Counts OWNED cycles without owner release; flags only, the token is never forced back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
      r_terr   <= 1'b0;
    end else if (r_state == ST_GRANT) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_OWNED && !w_rel[r_owner]) begin
      if (r_wd_cnt == WDW'(HOLD_TIMEOUT - 1)) r_terr <= 1'b1;
      if (r_wd_cnt != WDW'(HOLD_TIMEOUT))     r_wd_cnt <= r_wd_cnt + WDW'(1);
    end
  end

  assign timeout_err = r_terr;
`else
  assign timeout_err = BOOL_FALSE;
`endif

  assign sub_ack   = r_ack;
  assign owner     = r_owner;
  assign owned     = r_owned;
  assign grant_cnt = r_cnt;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_token_root_ctrl.sv
// Directed bench for token_root_ctrl: two ports, plus a CNT_W=2 instance sharing stimulus.
module tb_token_root_ctrl;

  localparam logic [1:0] I = 2'd0, R = 2'd1, L = 2'd2, X = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sub_req;
  logic [1:0] sub_ack, sub_ack2;
  logic       owner, owner2;
  logic       owned, owned2;
  logic [15:0] grant_cnt;
  logic [1:0]  grant_cnt2;
  logic       proto_err, proto_err2;
  logic       timeout_err, timeout_err2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  token_root_ctrl #(.NUM_PORTS(2), .HOLD_TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sub_req(sub_req), .sub_ack(sub_ack), .owner(owner),
    .owned(owned), .grant_cnt(grant_cnt), .proto_err(proto_err), .timeout_err(timeout_err)
  );

  token_root_ctrl #(.NUM_PORTS(2), .HOLD_TIMEOUT(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sub_req(sub_req), .sub_ack(sub_ack2), .owner(owner2),
    .owned(owned2), .grant_cnt(grant_cnt2), .proto_err(proto_err2), .timeout_err(timeout_err2)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input logic [1:0] p1, input logic [1:0] p0);
    sub_req = {p1, p0};
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_req(I, I);
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sub_ack !== 2'b00) begin n_errors++; $display("FAIL reset_ack got %b exp 00", sub_ack); end
    n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL reset_owner got %b exp 0", owner); end
    n_checks++; if (owned !== 1'b0) begin n_errors++; $display("FAIL reset_owned got %b exp 0", owned); end
    n_checks++; if (grant_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", grant_cnt); end
    n_checks++; if ({proto_err, timeout_err} !== 2'b00) begin n_errors++; $display("FAIL reset_errs got %b exp 00", {proto_err, timeout_err}); end
  endtask

  task automatic test_single_grant();
    do_reset();
    set_req(I, R); step();
    n_checks++; if (sub_ack !== 2'b01) begin n_errors++; $display("FAIL single_ack got %b exp 01", sub_ack); end
    n_checks++; if (owned !== 1'b0) begin n_errors++; $display("FAIL single_owned_grant got %b exp 0", owned); end
    set_req(I, L); step();
    n_checks++; if (sub_ack !== 2'b00) begin n_errors++; $display("FAIL single_ack_drop got %b exp 00", sub_ack); end
    n_checks++; if (owned !== 1'b1) begin n_errors++; $display("FAIL single_owned got %b exp 1", owned); end
    n_checks++; if (grant_cnt !== 16'd1) begin n_errors++; $display("FAIL single_cnt got %0d exp 1", grant_cnt); end
    set_req(I, X); step();
    n_checks++; if (owned !== 1'b0) begin n_errors++; $display("FAIL single_release got %b exp 0", owned); end
    set_req(I, I); step();
  endtask

  task automatic test_alternate();
    logic exp_own;
    do_reset();
    for (int g = 0; g < 4; g++) begin
      exp_own = g[0];
      set_req(R, R); step();
      n_checks++; if (sub_ack !== (exp_own ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL alt_ack[%0d] got %b exp owner %0d", g, sub_ack, exp_own); end
      n_checks++; if (owner !== exp_own) begin n_errors++; $display("FAIL alt_owner[%0d] got %0d exp %0d", g, owner, exp_own); end
      if (exp_own) set_req(L, R); else set_req(R, L);
      step();
      n_checks++; if (sub_ack !== 2'b00) begin n_errors++; $display("FAIL alt_ack_low[%0d] got %b exp 00", g, sub_ack); end
      if (exp_own) set_req(X, R); else set_req(R, X);
      step();
    end
    n_checks++; if (grant_cnt !== 16'd4) begin n_errors++; $display("FAIL alt_cnt got %0d exp 4", grant_cnt); end
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL alt_perr got %b exp 0", proto_err); end
  endtask

  task automatic test_proto_err();
    do_reset();
    set_req(I, R); step();
    set_req(I, L); step();
    set_req(X, L); step();
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL perr_owned got %b exp 1", proto_err); end
    n_checks++; if (owned !== 1'b1) begin n_errors++; $display("FAIL perr_owned_kept got %b exp 1", owned); end
    n_checks++; if (owner !== 1'b0) begin n_errors++; $display("FAIL perr_owner got %0d exp 0", owner); end
    set_req(I, L); step();
    n_checks++; if (owned !== 1'b1) begin n_errors++; $display("FAIL perr_still_owned got %b exp 1", owned); end
    // release from the grantee while the ack is still out
    do_reset();
    n_checks++; if (proto_err !== 1'b0) begin n_errors++; $display("FAIL perr_cleared got %b exp 0", proto_err); end
    set_req(I, R); step();
    set_req(I, X); step();
    n_checks++; if (proto_err !== 1'b1) begin n_errors++; $display("FAIL perr_grant got %b exp 1", proto_err); end
    n_checks++; if (owned !== 1'b1) begin n_errors++; $display("FAIL perr_grant_owned got %b exp 1", owned); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    set_req(R, I); step();
    n_checks++; if (sub_ack !== 2'b10) begin n_errors++; $display("FAIL midrst_pre_ack got %b exp 10", sub_ack); end
    rst_n = 1'b0; step();
    n_checks++; if (sub_ack !== 2'b00) begin n_errors++; $display("FAIL midrst_ack got %b exp 00", sub_ack); end
    n_checks++; if (owned !== 1'b0 || grant_cnt !== 16'd0) begin n_errors++; $display("FAIL midrst_state got owned=%b cnt=%0d exp 0/0", owned, grant_cnt); end
    rst_n = 1'b1; set_req(R, R); step();
    n_checks++; if (sub_ack !== 2'b01) begin n_errors++; $display("FAIL midrst_winner got %b exp 01", sub_ack); end
  endtask

  task automatic test_watchdog();
    logic exp_to;
    do_reset();
    set_req(I, R); step();
    set_req(I, L); step();
    for (int c = 1; c <= 10; c++) begin
      step();
`ifdef WATCHDOG_EN
      exp_to = (c >= 8);
`else
      exp_to = 1'b0;
`endif
      if (c == 7 || c == 8 || c == 10) begin
        n_checks++; if (timeout_err !== exp_to) begin n_errors++; $display("FAIL wd_terr[%0d] got %b exp %b", c, timeout_err, exp_to); end
      end
    end
    n_checks++; if (owned !== 1'b1) begin n_errors++; $display("FAIL wd_owned got %b exp 1", owned); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp2;
    do_reset();
    for (int g = 1; g <= 5; g++) begin
      exp2 = (g >= 3) ? 2'd3 : 2'(g);
      set_req(I, R); step();
      n_checks++; if (sub_ack !== 2'b01) begin n_errors++; $display("FAIL b2b_ack[%0d] got %b exp 01", g, sub_ack); end
      set_req(I, L); step();
      n_checks++; if (grant_cnt2 !== exp2) begin n_errors++; $display("FAIL b2b_cnt2[%0d] got %0d exp %0d", g, grant_cnt2, exp2); end
      n_checks++; if (grant_cnt !== 16'(g)) begin n_errors++; $display("FAIL b2b_cnt[%0d] got %0d exp %0d", g, grant_cnt, g); end
      set_req(I, X); step();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sub_req = '0;
    test_reset();
    test_single_grant();
    test_alternate();
    test_proto_err();
    test_reset_mid_grant();
    test_watchdog();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
